// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the data-side SRAM responder and the stall controller.
package data_sram_responder_pkg;

  typedef enum logic [1:0] {
    DSR_IDLE = 2'd0,
    DSR_BUSY = 2'd1,
    DSR_DONE = 2'd2
  } dsr_state_e;

  localparam int DSR_DATA_W = 32;
  localparam int DSR_WEN_W  = 4;

  // Stall controller constants
  localparam int   StallBus = 6;
  localparam logic Stop     = 1'b1;
  localparam logic NoStop   = 1'b0;

endpackage

// File: rtl/data_sram_responder_dram_bytewrite.sv
// Byte-lane writable word array with a single registered read port.
module dram_bytewrite
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [DSR_WEN_W-1:0]  wen,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [DSR_DATA_W-1:0] wdata,
  output logic [DSR_DATA_W-1:0] rdata
);

  logic [DSR_DATA_W-1:0] mem [2**ADDR_WIDTH];
  logic [DSR_DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[idx];
  end

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DSR_WEN_W; i++) begin
        if (wen[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM slave: serves EX-stage load/store requests with WAIT_CYCLES wait states,
// stalling the pipeline while an access is outstanding.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq
);

  localparam bit       HAS_WAIT = (WAIT_CYCLES != 0);
  localparam logic [3:0] CNT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dsr_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       access;
  logic       we, re;
  logic       stall_c;

  logic [ADDR_WIDTH-1:0] idx;
  logic                  unused_addr_bits;

  assign idx              = data_sram_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

  // access marks the edge at which the array write or rdata load happens
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    if (!HAS_WAIT) begin
      access = data_sram_en;
    end else begin
      case (state_q)
        DSR_IDLE: begin
          if (data_sram_en) begin
            cnt_d = CNT_LOAD;
            if (CNT_LOAD == 4'd0) begin
              state_d = DSR_DONE;
              access  = 1'b1;
            end else begin
              state_d = DSR_BUSY;
            end
          end
        end
        DSR_BUSY: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = DSR_DONE;
            access  = 1'b1;
          end
        end
        // The request still on the bus here is the one just served.
        DSR_DONE: state_d = DSR_IDLE;
        default:  state_d = DSR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DSR_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign we = rst & access & (|data_sram_wen);
  assign re = rst & access & (data_sram_wen == 4'b0000);

  assign stall_c  = rst & (((state_q == DSR_IDLE) & data_sram_en & HAS_WAIT) |
                           (state_q == DSR_BUSY));
  assign stallreq = stall_c ? Stop : NoStop;

  dram_bytewrite #(.ADDR_WIDTH(ADDR_WIDTH)) u_dram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .re    (re),
    .wen   (data_sram_wen),
    .idx   (idx),
    .wdata (data_sram_wdata),
    .rdata (data_sram_rdata)
  );

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench: one responder with no wait states and one with three.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en0, en3;
  logic [3:0]  wen0, wen3;
  logic [31:0] addr0, addr3, wd0, wd3;
  logic [31:0] rd0, rd3;
  logic        st0, st3;

  int checks = 0;
  int fails  = 0;

  logic [31:0] mdl0 [1024];
  logic [31:0] mdl3 [1024];
  logic [31:0] last0 = '0, last3 = '0;
  logic [31:0] q0[$];
  logic [31:0] q3[$];

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .data_sram_en(en0), .data_sram_wen(wen0),
    .data_sram_addr(addr0), .data_sram_wdata(wd0), .data_sram_rdata(rd0), .stallreq(st0));

  data_sram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .data_sram_en(en3), .data_sram_wen(wen3),
    .data_sram_addr(addr3), .data_sram_wdata(wd3), .data_sram_rdata(rd3), .stallreq(st3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] w);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Reference model: word array, last-read register, expected rdata after each access.
  task automatic issue(input int d, input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd);
    int idx;
    idx = int'((a >> 2) & 32'd1023);
    if (d == 0) begin
      if (w == 4'b0) last0 = mdl0[idx];
      else           mdl0[idx] = merge(mdl0[idx], wd, w);
      q0.push_back(last0);
    end else begin
      if (w == 4'b0) last3 = mdl3[idx];
      else           mdl3[idx] = merge(mdl3[idx], wd, w);
      q3.push_back(last3);
    end
  endtask

  task automatic acc0(input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd);
    en0 = 1'b1; wen0 = w; addr0 = a; wd0 = wd;
    issue(0, w, a, wd);
    @(negedge clk);
    chk("stall0", {31'b0, st0}, 32'd0);
    @(posedge clk); #1;
    en0 = 1'b0; wen0 = 4'b0;
  endtask

  task automatic acc3(input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd);
    en3 = 1'b1; wen3 = w; addr3 = a; wd3 = wd;
    issue(3, w, a, wd);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("stall3_cyc%0d", c), {31'b0, st3}, (c < 3) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    en3 = 1'b0; wen3 = 4'b0;
  endtask

  // Monitor: completion of an access is visible on the responder interface.
  logic arm0 = 1'b0, pst3 = 1'b0;
  always @(negedge clk) begin
    if (arm0) begin
      if (q0.size() == 0) begin
        checks++; fails++;
        $display("FAIL mon0 unexpected completion rdata=%h", rd0);
      end else chk("mon0_rdata", rd0, q0.pop_front());
    end
    arm0 = rst && en0;
    if (rst && pst3 && !st3 && en3) begin
      if (q3.size() == 0) begin
        checks++; fails++;
        $display("FAIL mon3 unexpected completion rdata=%h", rd3);
      end else chk("mon3_rdata", rd3, q3.pop_front());
    end
    pst3 = rst && st3;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int d, k;
    logic [3:0]  w;
    logic [31:0] a;
    rst = 1'b0;
    en0 = 0; wen0 = 0; addr0 = 0; wd0 = 0;
    en3 = 0; wen3 = 0; addr3 = 0; wd3 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rd0", rd0, 32'd0);
    chk("reset_rd3", rd3, 32'd0);
    chk("reset_st0", {31'b0, st0}, 32'd0);
    chk("reset_st3", {31'b0, st3}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // no wait states: full word, byte lane, alias
    acc0(4'hF, 32'h10, 32'hDEADBEEF);
    chk("rd0_unchanged_by_write", rd0, 32'd0);
    acc0(4'h0, 32'h10, 32'h0);
    chk("rd0_full_word", rd0, 32'hDEADBEEF);
    acc0(4'b0100, 32'h12, 32'h00AA0000);
    chk("rd0_after_lane_write", rd0, 32'hDEADBEEF);
    acc0(4'h0, 32'h10, 32'h0);
    chk("rd0_lane_merge", rd0, 32'hDEAABEEF);
    acc0(4'hF, 32'h1010, 32'hCAFEF00D);
    acc0(4'h0, 32'h0010, 32'h0);
    chk("rd0_alias", rd0, 32'hCAFEF00D);

    // three wait states: back-to-back write then read
    acc3(4'hF, 32'h20, 32'h12345678);
    acc3(4'h0, 32'h20, 32'h0);
    chk("rd3_wr_then_rd", rd3, 32'h12345678);

    // reset mid-BUSY drops the pending write
    acc3(4'hF, 32'h30, 32'h11111111);
    acc3(4'h0, 32'h30, 32'h0);
    chk("rd3_pre_reset", rd3, 32'h11111111);
    en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h30; wd3 = 32'hFFFFFFFF;
    @(negedge clk);
    chk("stall3_before_reset", {31'b0, st3}, 32'd1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("reset_mid_busy_st3", {31'b0, st3}, 32'd0);
    chk("reset_mid_busy_rd3", rd3, 32'd0);
    chk("reset_mid_busy_rd0", rd0, 32'd0);
    en3 = 1'b0; wen3 = 4'b0;
    last0 = '0; last3 = '0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    acc3(4'h0, 32'h30, 32'h0);
    chk("rd3_write_dropped", rd3, 32'h11111111);

    // randomized traffic over a small aliased pool
    for (int i = 0; i < 8; i++) begin
      acc0(4'hF, (32'h100 + i) << 2, $urandom());
      acc3(4'hF, (32'h100 + i) << 2, $urandom());
    end
    for (int n = 0; n < 80; n++) begin
      d = int'($urandom_range(0, 1));
      k = int'($urandom_range(0, 7));
      a = ($urandom() & 32'hFFFFF000) | ((32'h100 + k) << 2) | $urandom_range(0, 3);
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (d == 0) acc0(w, a, $urandom());
      else        acc3(w, a, $urandom());
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 32'd0);
    chk("q3_drained", q3.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Data-side memory responder that serves the load/store requests the EX stage issues on the `data_sram_*` interface. It returns the word the MEM stage extracts load results from. It holds a byte-lane-writable word array, applies a configurable number of wait states per access, and raises `stallreq` to the pipeline stall controller while an access is outstanding. It is the slave end of the data SRAM interface; the pipeline is the master.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; the array depth is 2^ADDR_WIDTH words.
- `WAIT_CYCLES`, default 0: extra cycles per access; the legal range is 0..15.
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `data_sram_en`  in  1  request valid.
- `data_sram_wen`  in  4  byte-lane write enables; nonzero means write, 0 means read.
- `data_sram_addr`  in  32  byte address.
- `data_sram_wdata`  in  32  store data, already lane-aligned by EX.
- `data_sram_rdata`  out  32  registered read word.
- `stallreq`  out  1  request to stall the EX stage and all earlier stages.

## Operation
- Word index is `addr[ADDR_WIDTH+1:2]`. Bits `addr[1:0]` and all bits above the index are ignored, so higher addresses alias onto the array.
- **Write:** lane i (`wdata[8i+7:8i]`) is written only if `wen[i]` is set. Other lanes are preserved. A write leaves `data_sram_rdata` unchanged.
- **Read:** always returns the full word. Byte/halfword selection and sign extension belong to the MEM stage.
- **FSM states:** IDLE, BUSY, DONE. 4-bit down-counter `cnt`.
- **`WAIT_CYCLES == 0`:**
  - The FSM stays in IDLE.
  - A request with `en=1` in IDLE is performed at the rising edge that ends the request cycle.
  - `stallreq` is never asserted.
- **`WAIT_CYCLES == N > 0`:**
  - IDLE with `en=1`: accept the request, load `cnt <= N-1`, go to BUSY if N>1, else go straight to DONE.
  - BUSY: decrement `cnt`. At the edge where `cnt==1`, go to DONE.
  - The access (array write or `rdata` load) occurs at the edge entering DONE.
  - DONE: `en` is ignored, because the still-presented request is the one just served. Go to IDLE unconditionally.
- `stallreq = (state==IDLE && en && N>0) || state==BUSY`. It is combinational from `en` and state, and is deasserted in DONE.
- **Master obligation:** the master holds `en`, `wen`, `addr` and `wdata` stable while `stallreq` is high. The responder does not re-latch them; it samples them at the access edge.
- `data_sram_rdata` holds the last read word until the next read completes.
- **Reset (`rst` low, any state):**
  - state becomes IDLE, `cnt` becomes 0, `data_sram_rdata` becomes 0, `stallreq` becomes 0, all immediately.
  - An in-flight access is dropped; a pending write does not occur.
  - Array contents are not reset.

## Timing
- Request presented in cycle T.
- N=0: the access occurs at the end of T. `rdata` is valid from T+1, which is the MEM cycle of that load.
- N>0:
  - `stallreq` is high in cycles T..T+N-1 and low in T+N (DONE).
  - `rdata` is valid from T+N. EX advances at the end of T+N, and the MEM stage reads `rdata` in T+N+1.
  - A new request is accepted at the earliest in T+N+1 (IDLE).
  - Back-to-back accesses therefore take N+1 cycles each.
- Write-then-read of the same word on consecutive accepted requests returns the new data. There is no bypass requirement because accesses are serialized.

## Structure
- **Shared package / defines header:**
  - state encoding `DSR_IDLE=2'd0`, `DSR_BUSY=2'd1`, `DSR_DONE=2'd2`;
  - data SRAM widths (32-bit data, 4-bit wen);
  - the existing `StallBus`, `Stop` and `NoStop` constants consumed by the stall controller.
- **Sub-module `dram_bytewrite`:** array of 2^ADDR_WIDTH x 32, one write port with 4 lane enables, and one read port registered into `rdata`. The FSM and counter live in `data_sram_responder`.

## Test plan
- **N=0, full-word write/read:** write 0xDEADBEEF, `wen=4'b1111`, addr 0x10. Then read 0x10. Expect `rdata=0xDEADBEEF` in the cycle after the read, `stallreq` constantly 0, and `rdata` unchanged by the write.
- **Byte-lane write:** after the first case, write `wen=4'b0100`, `wdata=0x00AA0000` at 0x12. Read 0x10 and expect 0xDEAABEEF (`addr[1:0]` ignored).
- **N=3 read at T:** expect `stallreq` high in T, T+1 and T+2, low in T+3, and `rdata` valid from T+3. Holding `en=1` through T+3 must not start a second access: `stallreq` stays low in T+3, and a new request at T+4 raises `stallreq` again.
- **N=3 back-to-back:** write then read of the same word (0x20, 0x12345678). The read returns 0x12345678, and the second `stallreq` pulse starts at T+4.
- **Reset mid-BUSY:** N=3, write 0xFFFFFFFF to 0x30 (old value 0x11111111), drive `rst` low in T+1. Expect `stallreq` and `rdata` to drop to 0 immediately. After release, reading 0x30 returns 0x11111111.
- **Aliasing:** with ADDR_WIDTH=10, write 0xCAFEF00D at 0x1010, then read 0x0010. Expect 0xCAFEF00D.
